// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache memory-side responder: FSM states,
// word width and the captured operation type.
package cache_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM: registered read data one cycle after rd_en,
// write committed on the edge where wr_en is high.
module mem_sp_ram
    import cache_mem_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Power-up contents only; the array is deliberately outside any reset.
    logic [WORD_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the data cache: accepts one refill or write-back,
// waits a fixed latency, then pulses mem_ready with read data or commits the write.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                LATENCY  = 4,
    parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_ready,
    output logic [31:0]       refill,
    output logic              busy,
    output logic              req_err
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t              state;
    state_t              next_state;
    logic [7:0]          cnt;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   ram_rdata;
    logic                err_q;
    logic                accept;
    logic                ram_rd_en;
    logic                ram_wr_en;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign accept           = (state == IDLE) && (req_rd || req_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_rd || req_wr) next_state = WAIT;
            WAIT:    if (cnt == 8'd0)      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A simultaneous rd+wr is treated as a write; the read is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && req_rd && req_wr;
            if (accept) begin
                cnt     <= LAT_M1;
                op_q    <= req_wr ? OP_WR : OP_RD;
                addr_q  <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
            end else if ((state == WAIT) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Read is launched on the last WAIT cycle so the RAM output is valid in RESP;
    // reset at the RESP edge suppresses the write.
    assign ram_rd_en = (state == WAIT) && (cnt == 8'd0) && (op_q == OP_RD);
    assign ram_wr_en = (state == RESP) && (op_q == OP_WR) && !rst;

    mem_sp_ram #(
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) u_ram (
        .clk   (clk),
        .rd_en (ram_rd_en),
        .wr_en (ram_wr_en),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        mem_ready = 1'b0;
        busy      = 1'b0;
        refill    = '0;
        case (state)
            WAIT: begin
                busy = 1'b1;
            end
            RESP: begin
                mem_ready = 1'b1;
                busy      = 1'b1;
                refill    = (op_q == OP_RD) ? ram_rdata : '0;
            end
            default: begin
                mem_ready = 1'b0;
            end
        endcase
    end

    assign req_err = err_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench: a LATENCY=4 instance for the main scenarios
// and a LATENCY=1 instance for back-to-back held requests.
module tb_cache_mem_responder;

    localparam logic [31:0] INIT = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd [2];
    logic        req_wr [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        mem_ready [2];
    logic [31:0] refill [2];
    logic        busy [2];
    logic        req_err [2];

    int          checks = 0;
    int          errors = 0;
    int          lastLat;
    logic [31:0] lastData;
    logic        lastErr;
    logic        lastBusy;
    logic        afterReady;
    logic [31:0] afterRefill;
    logic        afterBusy;
    int          readyCount;
    int          readyIdx [3];
    logic [31:0] readyData [3];

    always #5 clk = ~clk;

    cache_mem_responder #(.ADDR_W(10), .LATENCY(4), .INIT_VAL(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd[0]),
        .req_wr    (req_wr[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .mem_ready (mem_ready[0]),
        .refill    (refill[0]),
        .busy      (busy[0]),
        .req_err   (req_err[0])
    );

    cache_mem_responder #(.ADDR_W(10), .LATENCY(1), .INIT_VAL(INIT)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd[1]),
        .req_wr    (req_wr[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .mem_ready (mem_ready[1]),
        .refill    (refill[1]),
        .busy      (busy[1]),
        .req_err   (req_err[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Drives the request inputs of one instance on a falling edge.
    task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_rd[sel]    = rd;
        req_wr[sel]    = wr;
        req_addr[sel]  = addr;
        req_wdata[sel] = wdata;
    endtask

    // One full transaction: pulse the request for one cycle, measure latency to
    // mem_ready, then look at the cycle after the response.
    task automatic transact(input int sel, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(sel, rd, wr, addr, wdata);
        lastLat  = -1;
        lastData = '0;
        lastErr  = 1'b0;
        lastBusy = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                lastBusy    = busy[sel];
                lastErr     = req_err[sel];
                req_rd[sel] = 1'b0;
                req_wr[sel] = 1'b0;
            end
            if (mem_ready[sel]) begin
                lastLat  = i;
                lastData = refill[sel];
                break;
            end
        end
        @(negedge clk);
        afterReady  = mem_ready[sel];
        afterRefill = refill[sel];
        afterBusy   = busy[sel];
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_rd[s]    = 1'b0;
            req_wr[s]    = 1'b0;
            req_addr[s]  = '0;
            req_wdata[s] = '0;
        end

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(mem_ready[0]), 32'd0);
        checkOutput("rst_refill", refill[0], 32'd0);
        checkOutput("rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("rst_err", 32'(req_err[0]), 32'd0);
        rst = 1'b0;

        // First read: latency and power-up contents
        transact(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        checkOutput("rd0_latency", 32'(lastLat), 32'd5);
        checkOutput("rd0_busy", 32'(lastBusy), 32'd1);
        checkOutput("rd0_data", lastData, INIT);
        checkOutput("rd0_ready_drop", 32'(afterReady), 32'd0);
        checkOutput("rd0_refill_drop", afterRefill, 32'd0);
        checkOutput("rd0_busy_drop", 32'(afterBusy), 32'd0);

        // Write-back then refill, plus an aliased address
        transact(0, 1'b0, 1'b1, 32'h1234_5678, 32'h89AB_CDEF);
        checkOutput("wr1_latency", 32'(lastLat), 32'd5);
        checkOutput("wr1_refill_zero", lastData, 32'd0);
        checkOutput("wr1_no_err", 32'(lastErr), 32'd0);
        transact(0, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        checkOutput("rd1_data", lastData, 32'h89AB_CDEF);
        transact(0, 1'b1, 1'b0, 32'h0000_1678, 32'h0);
        checkOutput("rd1_alias_data", lastData, 32'h89AB_CDEF);

        // Simultaneous rd+wr: write wins and req_err pulses
        transact(0, 1'b1, 1'b1, 32'h9ABC_DEF0, 32'hDEAD_BEEF);
        checkOutput("conf_err", 32'(lastErr), 32'd1);
        checkOutput("conf_latency", 32'(lastLat), 32'd5);
        checkOutput("conf_refill_zero", lastData, 32'd0);
        transact(0, 1'b1, 1'b0, 32'h9ABC_DEF0, 32'h0);
        checkOutput("conf_rd_data", lastData, 32'hDEAD_BEEF);
        checkOutput("rd_no_err", 32'(lastErr), 32'd0);

        // Request during WAIT is ignored
        applyStimulus(0, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        readyCount = 0;
        lastData   = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) req_rd[0] = 1'b0;
            if (i == 1) begin
                req_rd[0]   = 1'b1;
                req_addr[0] = 32'h0000_0040;
            end
            if (i == 2) req_rd[0] = 1'b0;
            if (mem_ready[0]) begin
                readyCount++;
                lastData = refill[0];
            end
        end
        checkOutput("busy_drop_count", 32'(readyCount), 32'd1);
        checkOutput("busy_drop_data", lastData, 32'h89AB_CDEF);

        // Reset during WAIT aborts the write
        applyStimulus(0, 1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111);
        @(negedge clk);
        req_wr[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstwait_busy", 32'(busy[0]), 32'd0);
        readyCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ready[0]) readyCount++;
        end
        checkOutput("rstwait_no_ready", 32'(readyCount), 32'd0);
        transact(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("rstwait_old_data", lastData, INIT);

        // Reset in RESP also blocks the write
        applyStimulus(0, 1'b0, 1'b1, 32'h0000_0080, 32'h2222_2222);
        readyCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) req_wr[0] = 1'b0;
            if (mem_ready[0]) begin
                readyCount++;
                rst = 1'b1;
                break;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstresp_seen", 32'(readyCount), 32'd1);
        transact(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        checkOutput("rstresp_old_data", lastData, INIT);

        // LATENCY=1 instance: preload, then back-to-back held reads
        transact(1, 1'b0, 1'b1, 32'h0000_0100, 32'hC0DE_0001);
        checkOutput("l1_wr_latency", 32'(lastLat), 32'd2);
        transact(1, 1'b0, 1'b1, 32'h0000_0104, 32'hC0DE_0002);
        transact(1, 1'b0, 1'b1, 32'h0000_0108, 32'hC0DE_0003);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        readyCount = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mem_ready[1] && readyCount < 3) begin
                readyIdx[readyCount]  = i;
                readyData[readyCount] = refill[1];
                readyCount++;
                req_addr[1] = 32'h0000_0100 + 32'(readyCount * 4);
                if (readyCount == 3) req_rd[1] = 1'b0;
            end
        end
        checkOutput("l1_count", 32'(readyCount), 32'd3);
        checkOutput("l1_first_idx", 32'(readyIdx[0]), 32'd2);
        checkOutput("l1_gap0", 32'(readyIdx[1] - readyIdx[0]), 32'd3);
        checkOutput("l1_gap1", 32'(readyIdx[2] - readyIdx[1]), 32'd3);
        checkOutput("l1_data0", readyData[0], 32'hC0DE_0001);
        checkOutput("l1_data1", readyData[1], 32'hC0DE_0002);
        checkOutput("l1_data2", readyData[2], 32'hC0DE_0003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
